// File: rtl/apb_pwm_capture_pkg.sv
// Shared definitions for the APB PWM capture peripheral: register byte
// offsets, STATUS bit positions and the per-channel measurement state.
package apb_pwm_capture_pkg;

   // Byte offsets; only PADDR[4:2] is decoded.
   localparam logic [4:0] ADDR_CTRL    = 5'h00;
   localparam logic [4:0] ADDR_STATUS  = 5'h04;
   localparam logic [4:0] ADDR_HIGH1   = 5'h08;
   localparam logic [4:0] ADDR_PERIOD1 = 5'h0C;
   localparam logic [4:0] ADDR_HIGH2   = 5'h10;
   localparam logic [4:0] ADDR_PERIOD2 = 5'h14;
   localparam logic [4:0] ADDR_TIMEOUT = 5'h18;

   // STATUS bit positions
   localparam int unsigned ST_VALID1 = 0;
   localparam int unsigned ST_VALID2 = 1;
   localparam int unsigned ST_OVR1   = 2;
   localparam int unsigned ST_OVR2   = 3;
   localparam int unsigned ST_TMO1   = 4;
   localparam int unsigned ST_TMO2   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } chan_state_e;

endpackage

// File: rtl/apb_pwm_capture_channel.sv
// One capture channel: synchronizer, edge detector, measurement FSM with
// saturating counters, and the latched high-time / period results.
// done pulses for one cycle when a full period has been latched; tmo pulses
// for one cycle when the period counter hits the programmed timeout.
module pwm_capture_channel
   import apb_pwm_capture_pkg::*;
#(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap_in,
   input  logic             en,
   input  logic [CNT_W-1:0] timeout,
   output logic [CNT_W-1:0] high_q,
   output logic [CNT_W-1:0] period_q,
   output logic             done,
   output logic             tmo
);

   logic             sync1, sync2, sync3;
   logic             rise, fall;
   logic             timed_out;
   logic [CNT_W-1:0] hcnt, pcnt;
   chan_state_e      state;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= cap_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise      = sync2 & ~sync3;
   assign fall      = ~sync2 & sync3;
   assign timed_out = (timeout != '0) && (pcnt >= timeout);

   // Measurement FSM: counters, latched results and event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hcnt     <= '0;
         pcnt     <= '0;
         high_q   <= '0;
         period_q <= '0;
         done     <= 1'b0;
         tmo      <= 1'b0;
      end else begin
         done <= 1'b0;
         tmo  <= 1'b0;
         if (!en) begin
            state <= IDLE;
            hcnt  <= '0;
            pcnt  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     hcnt  <= CNT_W'(1);
                     pcnt  <= CNT_W'(1);
                     state <= HIGH;
                  end
               end
               HIGH: begin
                  if (timed_out) begin
                     tmo   <= 1'b1;
                     hcnt  <= '0;
                     pcnt  <= '0;
                     state <= IDLE;
                  end else if (fall) begin
                     pcnt  <= sat_inc(pcnt);
                     state <= LOW;
                  end else begin
                     hcnt <= sat_inc(hcnt);
                     pcnt <= sat_inc(pcnt);
                  end
               end
               LOW: begin
                  // A completing edge takes precedence over a coincident timeout
                  if (rise) begin
                     high_q   <= hcnt;
                     period_q <= pcnt;
                     done     <= 1'b1;
                     hcnt     <= CNT_W'(1);
                     pcnt     <= CNT_W'(1);
                     state    <= HIGH;
                  end else if (timed_out) begin
                     tmo   <= 1'b1;
                     hcnt  <= '0;
                     pcnt  <= '0;
                     state <= IDLE;
                  end else begin
                     pcnt <= sat_inc(pcnt);
                  end
               end
               default: begin
                  state <= IDLE;
                  hcnt  <= '0;
                  pcnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/apb_pwm_capture.sv
// APB3 slave measuring high time and period of two PWM inputs in PCLK cycles.
// Holds the APB decode, CTRL, TIMEOUT and W1C STATUS registers.
// Optional interrupt output enabled by defining PWM_CAPTURE_IRQ_EN.
module apb_pwm_capture
   import apb_pwm_capture_pkg::*;
#(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned TIMEOUT_RST = 2500000
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        cap_in1,
   input  logic        cap_in2
`ifdef PWM_CAPTURE_IRQ_EN
   ,
   output logic        irq
`endif
);

   logic             wr_en;
   logic             rd_en;
   logic [4:0]       addr_off;
   logic             en1, en2, irq_en;
   logic [CNT_W-1:0] timeout_q;
   logic [5:0]       status, st_set, st_clr;
   logic [CNT_W-1:0] high1, period1, high2, period2;
   logic             done1, done2, tmo1, tmo2;
   logic             unused;

   assign wr_en    = PSEL & PENABLE & PWRITE;
   assign rd_en    = PSEL & ~PWRITE;
   assign addr_off = {PADDR[4:2], 2'b00};
   assign PREADY   = 1'b1;
   assign PSLVERR  = 1'b0;
   assign unused   = ^{PADDR, PWDATA};

   pwm_capture_channel #(.CNT_W(CNT_W)) u_ch1 (
      .clk      (PCLK),
      .rst_n    (PRESERN),
      .cap_in   (cap_in1),
      .en       (en1),
      .timeout  (timeout_q),
      .high_q   (high1),
      .period_q (period1),
      .done     (done1),
      .tmo      (tmo1)
   );

   pwm_capture_channel #(.CNT_W(CNT_W)) u_ch2 (
      .clk      (PCLK),
      .rst_n    (PRESERN),
      .cap_in   (cap_in2),
      .en       (en2),
      .timeout  (timeout_q),
      .high_q   (high2),
      .period_q (period2),
      .done     (done2),
      .tmo      (tmo2)
   );

   // CTRL and TIMEOUT register writes
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         en1       <= 1'b0;
         en2       <= 1'b0;
         timeout_q <= CNT_W'(TIMEOUT_RST);
      end else if (wr_en) begin
         if (addr_off == ADDR_CTRL) begin
            en1 <= PWDATA[0];
            en2 <= PWDATA[1];
         end
         if (addr_off == ADDR_TIMEOUT) begin
            timeout_q <= PWDATA[CNT_W-1:0];
         end
      end
   end

`ifdef PWM_CAPTURE_IRQ_EN
   // Interrupt enable bit and registered interrupt output
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_en && (addr_off == ADDR_CTRL)) begin
            irq_en <= PWDATA[2];
         end
         irq <= irq_en & (|status);
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   // Hardware set and software write-1-to-clear requests for STATUS
   always_comb begin
      st_set            = '0;
      st_set[ST_VALID1] = done1;
      st_set[ST_VALID2] = done2;
      st_set[ST_OVR1]   = done1 & status[ST_VALID1];
      st_set[ST_OVR2]   = done2 & status[ST_VALID2];
      st_set[ST_TMO1]   = tmo1;
      st_set[ST_TMO2]   = tmo2;
      st_clr            = (wr_en && (addr_off == ADDR_STATUS)) ? PWDATA[5:0] : '0;
   end

   // STATUS update; a hardware set wins over a same-cycle clear
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         status <= '0;
      end else begin
         status <= (status & ~st_clr) | st_set;
      end
   end

   // Combinational read mux, zero outside read transfers
   always_comb begin
      PRDATA = '0;
      if (rd_en) begin
         case (addr_off)
            ADDR_CTRL:    PRDATA = {29'd0, irq_en, en2, en1};
            ADDR_STATUS:  PRDATA = {26'd0, status};
            ADDR_HIGH1:   PRDATA = 32'(high1);
            ADDR_PERIOD1: PRDATA = 32'(period1);
            ADDR_HIGH2:   PRDATA = 32'(high2);
            ADDR_PERIOD2: PRDATA = 32'(period2);
            ADDR_TIMEOUT: PRDATA = 32'(timeout_q);
            default:      PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_pwm_capture.sv
// Scoreboard bench for apb_pwm_capture: APB reads push their expected value,
// a monitor pops and compares at every read access phase.
module tb_apb_pwm_capture;

   localparam logic [31:0] A_CTRL    = 32'h00;
   localparam logic [31:0] A_STATUS  = 32'h04;
   localparam logic [31:0] A_HIGH1   = 32'h08;
   localparam logic [31:0] A_PERIOD1 = 32'h0C;
   localparam logic [31:0] A_HIGH2   = 32'h10;
   localparam logic [31:0] A_PERIOD2 = 32'h14;
   localparam logic [31:0] A_TIMEOUT = 32'h18;

   logic        PCLK = 1'b0;
   logic        PRESERN;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic        cap_in1, cap_in2;
`ifdef PWM_CAPTURE_IRQ_EN
   logic        irq;
`endif

   logic [31:0] exp_q[$];
   string       name_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   apb_pwm_capture #(.CNT_W(24), .TIMEOUT_RST(2500000)) dut (
      .PCLK    (PCLK),
      .PRESERN (PRESERN),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .cap_in1 (cap_in1),
      .cap_in2 (cap_in2)
`ifdef PWM_CAPTURE_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      cycles(1);
      PENABLE = 1'b1;
      cycles(1);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      cycles(1);
      PENABLE = 1'b1;
      cycles(1);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic pulse1(input int h, input int l);
      cap_in1 = 1'b1; cycles(h);
      cap_in1 = 1'b0; cycles(l);
   endtask

   task automatic pulse2(input int h, input int l);
      cap_in2 = 1'b1; cycles(h);
      cap_in2 = 1'b0; cycles(l);
   endtask

   // Monitor: compare every read access phase against the scoreboard
   initial begin
      forever begin
         @(negedge PCLK);
         if (PRESERN === 1'b1 && PSEL && PENABLE && !PWRITE) begin
            chk("PREADY", {31'd0, PREADY}, 32'd1);
            chk("PSLVERR", {31'd0, PSLVERR}, 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_read: got 0x%08h, expected no read", PRDATA);
            end else begin
               chk(name_q.pop_front(), PRDATA, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; cap_in1 = 1'b0; cap_in2 = 1'b0;
      cycles(3);
      chk("PREADY_reset", {31'd0, PREADY}, 32'd1);
      chk("PRDATA_reset", PRDATA, 32'd0);
      PRESERN = 1'b1;
      cycles(2);

      // Reset values and address decode
      apb_read(A_CTRL,    32'd0,       "rst_CTRL");
      apb_read(A_STATUS,  32'd0,       "rst_STATUS");
      apb_read(A_HIGH1,   32'd0,       "rst_HIGH1");
      apb_read(A_PERIOD1, 32'd0,       "rst_PERIOD1");
      apb_read(A_HIGH2,   32'd0,       "rst_HIGH2");
      apb_read(A_PERIOD2, 32'd0,       "rst_PERIOD2");
      apb_read(A_TIMEOUT, 32'd2500000, "rst_TIMEOUT");
      apb_write(32'h1C, 32'hFFFF_FFFF);
      apb_read(32'h1C,    32'd0,       "unmapped_read");
      apb_read(32'h118,   32'd2500000, "upper_addr_ignored");
      apb_read(A_CTRL,    32'd0,       "unmapped_write_ignored");

      // Channel 1: 150 high / 1850 low, three periods
      apb_write(A_CTRL, 32'h1);
      apb_read(A_CTRL, 32'h1, "CTRL_en1");
      fork
         begin
            pulse1(150, 1850);
            pulse1(150, 1850);
            cap_in1 = 1'b1; cycles(150); cap_in1 = 1'b0;
         end
         begin
            cycles(2160);
            apb_read(A_HIGH1,   32'd150,  "HIGH1_first");
            apb_read(A_PERIOD1, 32'd2000, "PERIOD1_first");
            apb_read(A_STATUS,  32'h01,   "STATUS_valid1");
         end
      join
      apb_read(A_STATUS,  32'h05,   "STATUS_ovr1");
      apb_read(A_HIGH1,   32'd150,  "HIGH1_third");
      apb_read(A_PERIOD1, 32'd2000, "PERIOD1_third");
      apb_write(A_STATUS, 32'h05);
      apb_read(A_STATUS,  32'h00,   "STATUS_w1c");

      // W1C of valid1 on the same edge that done sets it
      fork
         begin
            cap_in1 = 1'b1; cycles(150); cap_in1 = 1'b0;
         end
         begin
            cycles(2);
            apb_write(A_STATUS, 32'h01);
         end
      join
      apb_read(A_STATUS, 32'h01,  "STATUS_set_wins");
      apb_read(A_HIGH1,  32'd150, "HIGH1_fourth");

      // Channel 2 timeout
      apb_write(A_CTRL, 32'h2);
      apb_write(A_STATUS, 32'h3F);
      apb_read(A_STATUS, 32'h00, "STATUS_cleared");
      apb_write(A_TIMEOUT, 32'd500);
      apb_read(A_TIMEOUT, 32'd500, "TIMEOUT_rw");
      fork
         begin
            cap_in2 = 1'b1; cycles(20); cap_in2 = 1'b0;
         end
         begin
            cycles(502);
            apb_read(A_STATUS, 32'h00, "tmo2_not_yet");
            apb_read(A_STATUS, 32'h20, "tmo2_set");
         end
      join
      apb_read(A_HIGH2,   32'd0, "HIGH2_after_tmo");
      apb_read(A_PERIOD2, 32'd0, "PERIOD2_after_tmo");

      // After timeout the channel is idle; TIMEOUT=0 disables the limit
      apb_write(A_TIMEOUT, 32'd0);
      apb_write(A_STATUS, 32'h20);
      pulse2(40, 760);
      pulse2(40, 760);
      apb_read(A_HIGH2,   32'd40,  "HIGH2_after_idle");
      apb_read(A_PERIOD2, 32'd800, "PERIOD2_after_idle");
      apb_read(A_STATUS,  32'h02,  "STATUS_valid2_no_tmo");

      // Disable channel 1 mid-HIGH, re-enable, then measure 100/600
      apb_write(A_CTRL, 32'h1);
      apb_write(A_STATUS, 32'h3F);
      fork
         begin
            cap_in1 = 1'b1; cycles(150); cap_in1 = 1'b0; cycles(850);
            pulse1(100, 500);
            cap_in1 = 1'b1; cycles(100); cap_in1 = 1'b0;
         end
         begin
            cycles(50);
            apb_write(A_CTRL, 32'h0);
            cycles(5);
            apb_write(A_CTRL, 32'h1);
            cycles(950);
            apb_read(A_STATUS, 32'h00, "no_valid_after_reenable");
         end
      join
      apb_read(A_HIGH1,   32'd100, "HIGH1_reenable");
      apb_read(A_PERIOD1, 32'd600, "PERIOD1_reenable");
      apb_read(A_STATUS,  32'h01,  "STATUS_reenable");

`ifdef PWM_CAPTURE_IRQ_EN
      // Interrupt follows STATUS by one cycle
      apb_write(A_CTRL, 32'h5);
      apb_write(A_STATUS, 32'h3F);
      cycles(2);
      chk("irq_idle", {31'd0, irq}, 32'd0);
      pulse1(100, 100);
      cap_in1 = 1'b1;
      cycles(4);
      chk("irq_before", {31'd0, irq}, 32'd0);
      cycles(1);
      chk("irq_set", {31'd0, irq}, 32'd1);
      cap_in1 = 1'b0;
      apb_read(A_CTRL, 32'h5, "CTRL_irq_en");
      apb_write(A_STATUS, 32'h3F);
      chk("irq_lag", {31'd0, irq}, 32'd1);
      cycles(1);
      chk("irq_clear", {31'd0, irq}, 32'd0);
`else
      apb_write(A_CTRL, 32'h7);
      apb_read(A_CTRL, 32'h3, "CTRL_irq_en_absent");
`endif

      cycles(3);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
